// File: rtl/lut_reduce_pkg.sv
// Shared types and elaboration-time helpers for the pipelined LUT reduction tree.
// Tree geometry functions are evaluated at elaboration to size stages and offsets.
package lut_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NAND = 2'b11
    } mode_e;

    // Deepest tree: 256 lanes reduced by 2-input nodes
    localparam int unsigned MAX_LEVELS = 8;

    function automatic int unsigned nodes_at(int unsigned width, int unsigned k,
                                             int unsigned level);
        int unsigned n;
        n = width;
        for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
            if (i < level) n = (n + k - 1) / k;
        end
        return n;
    endfunction

    function automatic int unsigned levels_for(int unsigned width, int unsigned k);
        int unsigned lv;
        lv = 0;
        for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
            if (nodes_at(width, k, i) > 1) lv = i + 1;
        end
        return lv;
    endfunction

    // Bit offset of a level inside the flattened tree vector (level 0 first)
    function automatic int unsigned tree_offset(int unsigned width, int unsigned k,
                                                int unsigned level);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i <= MAX_LEVELS; i++) begin
            if (i < level) off = off + nodes_at(width, k, i);
        end
        return off;
    endfunction

    function automatic logic identity(mode_e mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

endpackage

// File: rtl/lut_reduce_if.sv
// Sample/result bundle of the reduction pipe; clock and reset stay plain ports.
interface lut_reduce_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) ();
    import lut_reduce_pkg::*;

    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic [WIDTH-1:0]  in_mask;
    mode_e             in_mode;
    logic              count_clr;
    logic              out_valid;
    logic              out1;
    logic [CNT_W-1:0]  match_count;
    logic              count_sat;

    modport master (
        output in_valid, in_data, in_mask, in_mode, count_clr,
        input  out_valid, out1, match_count, count_sat
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_mode, count_clr,
        output out_valid, out1, match_count, count_sat
    );

endinterface

// File: rtl/lut_reduce_stage.sv
// One registered tree level: groups of LUT_K bits reduced per node, with valid and
// mode travelling alongside so each sample is reduced under its own mode.
module lut_reduce_stage
    import lut_reduce_pkg::*;
#(
    parameter  int unsigned IN_W  = 8,
    parameter  int unsigned LUT_K = 6,
    localparam int unsigned OUT_W = (IN_W + LUT_K - 1) / LUT_K
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             i_valid,
    input  mode_e            i_mode,
    input  logic [IN_W-1:0]  i_data,
    output logic             o_valid,
    output mode_e            o_mode,
    output logic [OUT_W-1:0] o_data
);
    localparam int unsigned PAD_W = OUT_W * LUT_K;

    logic [PAD_W-1:0] w_padded;
    logic [LUT_K-1:0] w_group;
    logic [OUT_W-1:0] w_node;
    logic             r_valid;
    mode_e            r_mode;
    logic [OUT_W-1:0] r_data;

    // Partial last group is filled with the identity of this sample's mode
    always_comb begin
        w_padded = {PAD_W{identity(i_mode)}};
        w_padded[IN_W-1:0] = i_data;
        w_group = '0;
        w_node = '0;
        for (int unsigned n = 0; n < OUT_W; n++) begin
            w_group = w_padded[n*LUT_K +: LUT_K];
            case (i_mode)
                MODE_AND, MODE_NAND: w_node[n] = &w_group;
                MODE_OR:             w_node[n] = |w_group;
                default:             w_node[n] = ^w_group;
            endcase
        end
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_AND;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_data  <= w_node;
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;

endmodule

// File: rtl/lut_reduce_pipe.sv
// Fully pipelined K-ary LUT reduction of WIDTH masked lanes with selectable
// AND/OR/XOR/NAND, a register per level, and a saturating count of true results.
module lut_reduce_pipe
    import lut_reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LUT_K = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clock0,
    input  logic         reset,
    lut_reduce_if.slave  bus
);
    localparam int unsigned LEVELS = levels_for(WIDTH, LUT_K);
    localparam int unsigned TREE_W = tree_offset(WIDTH, LUT_K, LEVELS + 1);

    // All levels share one flat vector; level l occupies nodes_at(l) bits
    logic [TREE_W-1:0] w_tree;
    logic              w_valid [LEVELS+1];
    mode_e             w_mode  [LEVELS+1];
    logic [WIDTH-1:0]  w_masked;
    logic              w_result;
    logic [CNT_W-1:0]  w_count_nxt;

    logic              r_valid0;
    mode_e             r_mode0;
    logic [WIDTH-1:0]  r_data0;
    logic [CNT_W-1:0]  r_count;
    logic              r_sat;

    always_comb begin
        w_masked = (bus.in_data & bus.in_mask)
                 | (~bus.in_mask & {WIDTH{identity(bus.in_mode)}});
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            r_valid0 <= 1'b0;
            r_mode0  <= MODE_AND;
            r_data0  <= '0;
        end else begin
            r_valid0 <= bus.in_valid;
            r_mode0  <= bus.in_mode;
            r_data0  <= w_masked;
        end
    end

    assign w_tree[WIDTH-1:0] = r_data0;
    assign w_valid[0]        = r_valid0;
    assign w_mode[0]         = r_mode0;

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int unsigned IN_OFF  = tree_offset(WIDTH, LUT_K, l);
        localparam int unsigned IN_W    = nodes_at(WIDTH, LUT_K, l);
        localparam int unsigned OUT_OFF = tree_offset(WIDTH, LUT_K, l + 1);
        localparam int unsigned OUT_W   = nodes_at(WIDTH, LUT_K, l + 1);

        lut_reduce_stage #(
            .IN_W  (IN_W),
            .LUT_K (LUT_K)
        ) u_stage (
            .clock0  (clock0),
            .reset   (reset),
            .i_valid (w_valid[l]),
            .i_mode  (w_mode[l]),
            .i_data  (w_tree[IN_OFF +: IN_W]),
            .o_valid (w_valid[l+1]),
            .o_mode  (w_mode[l+1]),
            .o_data  (w_tree[OUT_OFF +: OUT_W])
        );
    end

    // NAND travels as AND through the tree and is inverted only here
    assign w_result = w_tree[TREE_W-1] ^ (w_mode[LEVELS] == MODE_NAND);

    always_comb begin
        w_count_nxt = r_count;
        if (bus.count_clr) begin
            w_count_nxt = '0;
        end else if (w_valid[LEVELS] && w_result && !(&r_count)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_sat   <= &w_count_nxt;
        end
    end

    assign bus.out_valid   = w_valid[LEVELS];
    assign bus.out1        = w_result;
    assign bus.match_count = r_count;
    assign bus.count_sat   = r_sat;

endmodule

// File: tb/tb_lut_reduce_pipe.sv
// Self-checking bench: four parameterisations share one stimulus stream and are
// compared each cycle against a lane-counting reference model with known latencies.
module tb_lut_reduce_pipe;
    import lut_reduce_pkg::*;

    localparam int NI = 4;

    function automatic int unsigned width_of(int i);
        case (i)
            0, 1:    return 8;
            2:       return 13;
            default: return 37;
        endcase
    endfunction

    function automatic int unsigned k_of(int i);
        return (i == 2) ? 4 : 6;
    endfunction

    function automatic int unsigned cntw_of(int i);
        return (i == 1) ? 4 : 16;
    endfunction

    // Edges from capture to visible result: 8/6, 8/6, 13/4 -> 2; 37/6 -> 3
    function automatic int unsigned lat_of(int i);
        return (i == 3) ? 3 : 2;
    endfunction

    logic         clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    logic         s_rst, s_valid, s_clr;
    logic [255:0] s_data, s_mask;
    mode_e        s_mode;

    logic         o_v [NI];
    logic         o_d [NI];
    logic         o_sat [NI];
    logic [31:0]  o_cnt [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned W = width_of(g);
        localparam int unsigned K = k_of(g);
        localparam int unsigned C = cntw_of(g);

        lut_reduce_if #(.WIDTH(W), .CNT_W(C)) bus ();

        assign bus.in_valid  = s_valid;
        assign bus.in_data   = s_data[W-1:0];
        assign bus.in_mask   = s_mask[W-1:0];
        assign bus.in_mode   = s_mode;
        assign bus.count_clr = s_clr;

        lut_reduce_pipe #(.WIDTH(W), .LUT_K(K), .CNT_W(C)) dut (
            .clock0 (clock0),
            .reset  (s_rst),
            .bus    (bus)
        );

        assign o_v[g]   = bus.out_valid;
        assign o_d[g]   = bus.out1;
        assign o_cnt[g] = 32'(bus.match_count);
        assign o_sat[g] = bus.count_sat;
    end

    int           checks = 0;
    int           failures = 0;
    int unsigned  ec = 0;
    logic         h_v [16];
    logic         h_rst [16];
    mode_e        h_mode [16];
    logic [255:0] h_data [16];
    logic [255:0] h_mask [16];
    logic         exp_v [NI];
    logic         exp_d [NI];
    logic         exp_sat [NI];
    int unsigned  exp_cnt [NI];

    function automatic logic ref_reduce(logic [255:0] d, logic [255:0] m, mode_e md,
                                        int unsigned w);
        int unsigned ones, part;
        ones = 0;
        part = 0;
        for (int unsigned j = 0; j < w; j++) begin
            if (m[j]) begin
                part++;
                if (d[j]) ones++;
            end
        end
        case (md)
            MODE_AND: return ones == part;
            MODE_OR:  return ones > 0;
            MODE_XOR: return ones[0];
            default:  return ones != part;
        endcase
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Advance one edge, record what was sampled, and update the expected outputs
    task automatic tick();
        int unsigned slot, base, lat, cmax;
        logic v;
        @(posedge clock0);
        ec++;
        slot = ec % 16;
        h_v[slot]    = s_valid;
        h_rst[slot]  = s_rst;
        h_mode[slot] = s_mode;
        h_data[slot] = s_data;
        h_mask[slot] = s_mask;
        for (int i = 0; i < NI; i++) begin
            cmax = (32'd1 << cntw_of(i)) - 1;
            if (s_rst || s_clr) exp_cnt[i] = 0;
            else if (exp_v[i] && exp_d[i] && exp_cnt[i] != cmax) exp_cnt[i]++;
            exp_sat[i] = (exp_cnt[i] == cmax);
            lat = lat_of(i);
            v = 1'b0;
            if (ec >= lat) begin
                base = ec - lat;
                v = h_v[base % 16];
                for (int unsigned k = 0; k <= lat; k++) begin
                    if (h_rst[(base + k) % 16]) v = 1'b0;
                end
                exp_d[i] = ref_reduce(h_data[base % 16], h_mask[base % 16],
                                      h_mode[base % 16], width_of(i));
            end
            exp_v[i] = v;
        end
        #1;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; s_valid = 1'b1; s_clr = 1'b0;
        s_data = '1; s_mask = '1; s_mode = MODE_AND;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                s_rst = 1'b0; s_valid = 1'b0; s_data = '0;
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_d[i], o_cnt[i], o_sat[i]} !== 35'd0) begin
                    failures++;
                    $display("FAIL reset inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required 0/0/0/0",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i]);
                end
            end
        end
    endtask

    task automatic test_latency_and();
        for (int c = 0; c < 6; c++) begin
            s_mode = MODE_AND; s_mask = '1;
            s_valid = (c < 2);
            s_data = (c == 0) ? '1 : (c == 1) ? {{255{1'b1}}, 1'b0} : '0;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL latency inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({o_v[0], o_d[0]} !== ((c == 2) ? 2'b11 : 2'b10)) begin
                    failures++;
                    $display("FAIL latency_edge cyc%0d: valid,out1 got %b%b required %s",
                             c, o_v[0], o_d[0], (c == 2) ? "11" : "10");
                end
            end
        end
    endtask

    task automatic test_masking();
        logic [3:0] tbl;
        tbl = 4'b1101;
        for (int c = 0; c < 8; c++) begin
            s_valid = (c < 4);
            case (c)
                0:       begin s_mode = MODE_AND; s_data = 256'h7F; s_mask = 256'h7F; end
                1:       begin s_mode = MODE_OR;  s_data = 256'hFF; s_mask = 256'h00; end
                2:       begin s_mode = MODE_XOR; s_data = 256'h07; s_mask = 256'hFF; end
                3:       begin s_mode = MODE_AND; s_data = 256'h5A; s_mask = 256'h00; end
                default: begin s_mode = MODE_OR;  s_data = '0;     s_mask = '0;      end
            endcase
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL masking inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
            if (c >= 2 && c < 6) begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if ({o_v[i], o_d[i]} !== {1'b1, tbl[c-2]}) begin
                        failures++;
                        $display("FAIL mask_case%0d inst%0d: valid,out1 got %b%b required 1%b",
                                 c - 2, i, o_v[i], o_d[i], tbl[c-2]);
                    end
                end
            end
        end
    endtask

    task automatic test_modes();
        logic [3:0] seq;
        seq = 4'b0011;
        for (int c = 0; c < 9; c++) begin
            s_clr = (c == 0);
            s_valid = (c >= 1 && c <= 4);
            s_data = '1; s_mask = '1;
            case (c)
                1:       s_mode = MODE_AND;
                2:       s_mode = MODE_OR;
                3:       s_mode = MODE_XOR;
                4:       s_mode = MODE_NAND;
                default: s_mode = MODE_AND;
            endcase
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL modes inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if ({o_v[0], o_d[0]} !== {1'b1, seq[c-3]}) begin
                    failures++;
                    $display("FAIL mode_seq%0d: valid,out1 got %b%b required 1%b",
                             c - 3, o_v[0], o_d[0], seq[c-3]);
                end
            end
        end
        s_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_cnt[i] !== 32'd2) begin
                failures++;
                $display("FAIL mode_count inst%0d: got %0d required 2", i, o_cnt[i]);
            end
        end
    endtask

    task automatic test_counter();
        s_mode = MODE_AND; s_mask = '1; s_data = '1;
        for (int c = 0; c < 23; c++) begin
            s_clr = (c == 0);
            s_valid = (c >= 1 && c <= 17);
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL counter inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
        end
        checks++;
        if ({o_cnt[1], o_sat[1], o_cnt[0], o_sat[0]} !== {32'd15, 1'b1, 32'd17, 1'b0}) begin
            failures++;
            $display("FAIL saturate: cnt4/sat4/cnt16/sat16 got %0d/%b/%0d/%b required 15/1/17/0",
                     o_cnt[1], o_sat[1], o_cnt[0], o_sat[0]);
        end
        for (int c = 0; c < 6; c++) begin
            s_valid = (c == 0);
            s_clr = (c == 3);
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL clear inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
            if (c == 2) begin
                checks++;
                if ({o_v[1], o_d[1], o_cnt[1], o_sat[1]} !== {1'b1, 1'b1, 32'd15, 1'b1}) begin
                    failures++;
                    $display("FAIL sat_hold: valid/out1/count/sat got %b/%b/%0d/%b required 1/1/15/1",
                             o_v[1], o_d[1], o_cnt[1], o_sat[1]);
                end
            end
            if (c == 3) begin
                checks++;
                if ({o_cnt[1], o_sat[1], o_cnt[0]} !== 65'd0) begin
                    failures++;
                    $display("FAIL clear_wins: cnt4/sat4/cnt16 got %0d/%b/%0d required 0/0/0",
                             o_cnt[1], o_sat[1], o_cnt[0]);
                end
            end
        end
        s_clr = 1'b0;
    endtask

    task automatic test_params();
        s_mode = MODE_AND; s_mask = '1;
        for (int c = 0; c < 7; c++) begin
            s_valid = (c < 2);
            s_data = (c == 0) ? 256'h1FFF : (c == 1) ? 256'h1FFE : '0;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL params inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if ({o_v[2], o_v[2] & o_d[2], o_v[3]} !==
                    ((c == 2) ? 3'b110 : (c == 3) ? 3'b101 : (c == 4) ? 3'b001 : 3'b000)) begin
                    failures++;
                    $display("FAIL param_latency cyc%0d: v13,out13,v37 got %b%b%b", c,
                             o_v[2], o_d[2], o_v[3]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 9; c++) begin
            s_valid = (c < 3);
            s_rst = (c == 2);
            s_data = rand256();
            s_mask = '1;
            s_mode = mode_e'($urandom_range(0, 3));
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL midflight inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
                checks++;
                if (o_v[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL flushed inst%0d cyc%0d: out_valid got %b required 0", i, c, o_v[i]);
                end
            end
        end
        s_rst = 1'b0;
    endtask

    task automatic test_random();
        int unsigned sel;
        for (int c = 0; c < 306; c++) begin
            if (c < 300) begin
                s_rst   = ($urandom_range(0, 59) == 0);
                s_valid = ($urandom_range(0, 9) < 7);
                s_clr   = ($urandom_range(0, 19) == 0);
                s_mode  = mode_e'($urandom_range(0, 3));
                sel = $urandom_range(0, 7);
                s_data  = (sel == 2) ? '1 : rand256();
                sel = $urandom_range(0, 7);
                s_mask  = (sel == 0) ? '0 : (sel < 4) ? '1 : rand256();
            end else begin
                s_rst = 1'b0; s_valid = 1'b0; s_clr = 1'b0;
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({o_v[i], o_v[i] & o_d[i], o_cnt[i], o_sat[i]} !==
                    {exp_v[i], exp_v[i] & exp_d[i], exp_cnt[i], exp_sat[i]}) begin
                    failures++;
                    $display("FAIL random inst%0d cyc%0d: valid/out1/count/sat got %b/%b/%0d/%b required %b/%b/%0d/%b",
                             i, c, o_v[i], o_d[i], o_cnt[i], o_sat[i],
                             exp_v[i], exp_d[i], exp_cnt[i], exp_sat[i]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            h_v[k] = 1'b0; h_rst[k] = 1'b0; h_mode[k] = MODE_AND;
            h_data[k] = '0; h_mask[k] = '0;
        end
        for (int i = 0; i < NI; i++) begin
            exp_v[i] = 1'b0; exp_d[i] = 1'b0; exp_sat[i] = 1'b0; exp_cnt[i] = 0;
        end
        s_rst = 1'b1; s_valid = 1'b0; s_clr = 1'b0;
        s_data = '0; s_mask = '0; s_mode = MODE_AND;

        test_reset();
        test_latency_and();
        test_masking();
        test_modes();
        test_counter();
        test_params();
        test_reset_midflight();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_reduce_pipe.md
Name: lut_reduce_pipe

Overview:
- Parametrised, fully pipelined K-input LUT reduction tree: the next generation of the registered AND-tree CLB benchmark.
- Reduces WIDTH registered input bits to one bit with a runtime-selectable operation (AND/OR/XOR/NAND) and a per-lane mask.
- Places a register after every LUT level, carries a valid bit through the pipe, and keeps a saturating count of asserted results.
- Used as a CLB timing and packing benchmark for LUT-to-LUT paths of arbitrary depth.

Parameters:
- WIDTH, 8, number of input lanes; legal range 2..256.
- LUT_K, 6, fan-in per tree node; legal range 2..6.
- CNT_W, 16, width of the result counter; legal range 1..32.
- LEVELS, derived (not overridable), number of K-ary levels to reduce WIDTH to 1. WIDTH=8/K=6 gives 2; 13/4 gives 2; 37/6 gives 3.

Ports:
- clock0  in  1  single clock; all flops rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample qualifier.
- in_data  in  WIDTH  operand bits.
- in_mask  in  WIDTH  1 = lane participates; 0 = lane forced to identity.
- in_mode  in  2  00 AND, 01 OR, 10 XOR, 11 NAND.
- count_clr  in  1  synchronous clear of match_count.
- out_valid  out  1  result qualifier.
- out1  out  1  reduction result.
- match_count  out  CNT_W  number of results with out_valid=1 and out1=1.
- count_sat  out  1  high while match_count is all ones.

Behaviour:
- Clock and reset: clock0 only. reset is synchronous and active-high.
- Reset values: while reset is high, every pipeline data, valid and mode register clears to 0, including out_valid, out1, match_count and count_sat. Inputs are ignored during reset.
- Reset mid-flight: all in-flight samples are discarded and produce no out_valid.
- Stage 0 (input register): captures in_valid, in_mode and masked data every cycle, with no enable. Masked lanes are replaced by the identity value: 1 for AND/NAND, 0 for OR/XOR.
- Stages 1..LEVELS: each stage registers ceil(prev/LUT_K) node outputs. Each node combines up to LUT_K bits of the previous stage.
  - Pad bits in a partial group take the identity value of that sample's mode.
  - Mode and valid travel alongside the data, so every stage uses its own sample's mode.
- NAND: computed as AND through the tree, inverted only at the final stage.
- Latency: a sample accepted at edge t appears on out_valid/out1 after edge t+LEVELS, i.e. LEVELS+1 registers (3 for defaults).
- Throughput: one sample per cycle, no backpressure, no bubbles. Mode may change every cycle.
- Invalid data: when out_valid=0, out1 carries the stage data, which is don't-care. A bench checks out1 only when out_valid=1.
- All-masked sample: result is the identity value. AND gives 1, OR 0, XOR 0, NAND 0.
- Counter, evaluated on the final stage each cycle:
  - count_clr=1 sets match_count to 0; clear wins over a simultaneous increment.
  - Otherwise, out_valid & out1 increments match_count unless it is all ones; it saturates and holds, never wrapping.
  - count_sat is registered and equals (match_count == all ones). It drops on the cycle after a clear.

Decomposition:
- Package lut_reduce_pkg holds:
  - mode enum (MODE_AND, MODE_OR, MODE_XOR, MODE_NAND);
  - function levels_for(width,k), returning LEVELS;
  - function nodes_at(width,k,level), returning the node count per stage;
  - function identity(mode), returning the identity bit.
- Sub-module lut_reduce_stage: one registered tree level, parametrised by IN_W and LUT_K. It carries valid and mode, and is instantiated LEVELS times in a generate loop.
- The top level holds the input register, final inversion and counter.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 and data 0xFF, then release with in_valid=0 -> out_valid, out1, match_count and count_sat stay 0 throughout and afterwards.
- Latency/AND (defaults): mode AND, mask 0xFF, in_data 0xFF at edge t, then 0xFE at t+1 -> out_valid=1 with out1=1 after edge t+2, and out1=0 after edge t+3.
- Masking: AND data 0x7F mask 0x7F -> 1. OR data 0xFF mask 0x00 -> 0. XOR data 0x07 mask 0xFF -> 1. AND mask 0x00 -> 1.
- Per-cycle modes: back-to-back AND, OR, XOR, NAND, all with data 0xFF and mask 0xFF -> consecutive results 1,1,0,0. match_count ends at 2.
- Counter (CNT_W=4): 17 consecutive matching samples -> match_count=15, count_sat=1. Then count_clr concurrent with a matching result -> match_count=0, and count_sat=0 on the following cycle.
- Parameter sweep:
  - WIDTH=13/K=4: latency 3; data 0x1FFF -> 1, 0x1FFE -> 0.
  - WIDTH=37/K=6: latency 4.
  - Assert reset for 1 cycle with 3 samples in flight -> no out_valid for those samples.
